// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions used by both the display encoder and the
// scan decoder, so both ends agree on one hex glyph table.
//   SEG_HEX      : active-low {g,f,e,d,c,b,a} glyphs for nibbles 0..F
//   seg_decode() : glyph -> {hit, nibble}; exact match only
//   seg_encode() : nibble -> glyph
//   scan_state_e : decoder FSM states
package sevenseg_pkg;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        ST_SCAN   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_e;

    // Returns {1'b1, nibble} on an exact table hit, otherwise all zeros.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_HEX[i]) begin
                r = {1'b1, 4'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/sevenseg_scan_decoder_sync2.sv
// Two-flop synchronizer for an asynchronous multi-bit bus.
//   clk, rst : clock, asynchronous active-high reset (flops load RESET_VAL)
//   d_i      : asynchronous input word
//   q_o      : synchronized word, two clocks behind d_i
module sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Receive-side monitor for a 4-digit multiplexed seven-segment display.
// Samples the scanned anode/segment lines, waits for each digit to be stable
// for SETTLE_CYCLES samples, decodes it to a nibble and rebuilds the 16-bit
// displayed word once all four digits have been seen.
//   clk, rst    : clock, asynchronous active-high reset
//   AN          : active-low anodes, AN[3] = leftmost digit
//   sevenPlus   : active-low {dp,g,f,e,d,c,b,a}; dp ignored
//   value       : last complete frame
//   frame_valid : 1-cycle pulse when value updates
//   digit_seen  : digits captured in the current frame
//   decode_err  : 1-cycle pulse, settled glyph not a hex digit
//   anode_err   : 1-cycle pulse, settled anode word not one-hot-low
//   stale       : no digit accepted for TIMEOUT_CYCLES
//   dbg_state   : current FSM state
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  AN,
    input  logic [7:0]  sevenPlus,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic [3:0]  digit_seen,
    output logic        decode_err,
    output logic        anode_err,
    output logic        stale,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Synchronized sample word S = {AN, seg[6:0]}; resets to "display blank".
    logic [10:0] s_w;
    logic [3:0]  s_an;
    logic        unused_dp;

    sync2 #(.WIDTH(11), .RESET_VAL(11'h7FF)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i ({AN, sevenPlus[6:0]}),
        .q_o (s_w)
    );

    assign s_an      = s_w[10:7];
    assign unused_dp = sevenPlus[7];

    scan_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [10:0]   ref_q, ref_d;
    logic          eval;

    logic [15:0]   slots_q;
    logic [3:0]    seen_q, seen_d;
    logic [15:0]   value_q;
    logic          pend_q, pend_d;
    logic          fv_q, de_q, ae_q;
    logic [TW-1:0] tcnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        eval    = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (s_an != 4'hF) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CW'(1);
                    ref_d   = s_w;
                end
            end
            ST_SETTLE: begin
                if (s_an == 4'hF) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end else if (s_w != ref_q) begin
                    ref_d = s_w;
                    cnt_d = CW'(1);
                end else if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    // This sample is the SETTLE_CYCLES-th identical one.
                    cnt_d   = CW'(SETTLE_CYCLES);
                    eval    = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                if (s_w != ref_q) begin
                    if (s_an == 4'hF) begin
                        state_d = ST_SCAN;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_SETTLE;
                        ref_d   = s_w;
                        cnt_d   = CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    // Evaluation of the settled word held in ref_q.
    logic [3:0] an_low;
    logic       onehot;
    logic [1:0] idx;
    logic [4:0] dec;
    logic       accept;

    assign an_low = ~ref_q[10:7];
    assign onehot = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
    assign dec    = seg_decode(ref_q[6:0]);
    assign accept = eval && onehot && dec[4];

    always_comb begin
        case (an_low)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    // Frame completion is flagged one edge after the completing digit lands,
    // so value picks up that digit from slots_q.
    always_comb begin
        seen_d = seen_q;
        if (pend_q) begin
            seen_d = 4'd0;
        end
        if (accept) begin
            seen_d = seen_d | (4'b0001 << idx);
        end
        pend_d = accept && (seen_d == 4'hF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SCAN;
            cnt_q   <= '0;
            ref_q   <= '1;
            slots_q <= '0;
            seen_q  <= '0;
            value_q <= '0;
            pend_q  <= 1'b0;
            fv_q    <= 1'b0;
            de_q    <= 1'b0;
            ae_q    <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            if (accept) begin
                slots_q[{idx, 2'b00} +: 4] <= dec[3:0];
            end
            seen_q <= seen_d;
            pend_q <= pend_d;
            fv_q   <= pend_q;
            if (pend_q) begin
                value_q <= slots_q;
            end
            de_q <= eval && onehot && !dec[4];
            ae_q <= eval && !onehot;
            if (accept) begin
                tcnt_q <= '0;
            end else if (tcnt_q != TW'(TIMEOUT_CYCLES)) begin
                tcnt_q <= tcnt_q + TW'(1);
            end
        end
    end

    assign value       = value_q;
    assign frame_valid = fv_q;
    assign digit_seen  = seen_q;
    assign decode_err  = de_q;
    assign anode_err   = ae_q;
    assign stale       = (tcnt_q == TW'(TIMEOUT_CYCLES));
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
module tb_sevenseg_scan_decoder;

    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 300;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  AN;
    logic [7:0]  sevenPlus;
    logic [15:0] value;
    logic        frame_valid;
    logic [3:0]  digit_seen;
    logic        decode_err;
    logic        anode_err;
    logic        stale;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    sevenseg_scan_decoder #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .AN          (AN),
        .sevenPlus   (sevenPlus),
        .value       (value),
        .frame_valid (frame_valid),
        .digit_seen  (digit_seen),
        .decode_err  (decode_err),
        .anode_err   (anode_err),
        .stale       (stale),
        .dbg_state   (dbg_state)
    );

    // ---------------- reference model state ----------------
    logic [6:0]  hex_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [3:0]  m_slot [4];
    logic [3:0]  m_seen;
    logic [15:0] m_value;
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int exp_fv = 0, exp_de = 0, exp_ae = 0;

    int checks = 0;
    int errors = 0;

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   obs_fv = 0, obs_de = 0, obs_ae = 0, obs_coinc = 0;
    int   last_fv_cyc = -1;
    int   stale_fall_cyc = -1;
    logic stale_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            obs_fv++;
            obs_q.push_back(value);
            last_fv_cyc = cyc;
        end
        if (decode_err === 1'b1) obs_de++;
        if (anode_err === 1'b1) obs_ae++;
        if (decode_err === 1'b1 && frame_valid === 1'b1) obs_coinc++;
        if (stale_prev === 1'b1 && stale === 1'b0) stale_fall_cyc = cyc;
        stale_prev = stale;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_slot[i] = 4'd0;
        m_seen  = 4'd0;
        m_value = 16'd0;
    endtask

    // A digit that stayed put for SETTLE samples gets judged once.
    task automatic model_eval(input logic [3:0] an, input logic [6:0] seg);
        int zeros;
        int pos;
        int nib;
        zeros = 0;
        pos   = 0;
        nib   = -1;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
                zeros++;
                pos = i;
            end
        end
        for (int k = 0; k < 16; k++) begin
            if (hex_tab[k] == seg) nib = k;
        end
        if (zeros != 1) begin
            exp_ae++;
        end else if (nib < 0) begin
            exp_de++;
        end else begin
            m_slot[pos]  = 4'(nib);
            m_seen[pos]  = 1'b1;
            if (m_seen == 4'hF) begin
                m_value = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
                exp_q.push_back(m_value);
                exp_fv++;
                m_seen = 4'd0;
            end
        end
    endtask

    // ---------------- driver ----------------
    logic [10:0] prev_drv = 11'h7FF;
    int          step_t0 = 0;

    // Called at a negedge; drives a pattern for n sample edges.
    task automatic do_step(input logic [3:0] an, input logic [6:0] seg, input int n);
        if ({an, seg} == prev_drv && an != 4'hF) begin
            AN        = 4'hF;
            sevenPlus = 8'hFF;
            @(negedge clk);
        end
        AN        = an;
        sevenPlus = {1'($urandom_range(0, 1)), seg};
        step_t0   = cyc;
        prev_drv  = {an, seg};
        repeat (n) @(negedge clk);
        if (an != 4'hF && n >= SETTLE) model_eval(an, seg);
    endtask

    task automatic digit(input int pos, input logic [3:0] nib, input int n);
        do_step(~(4'b0001 << pos), hex_tab[nib], n);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        AN        = 4'hF;
        sevenPlus = 8'hFF;
        prev_drv  = 11'h7FF;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_all(input string tag);
        do_step(4'hF, 7'h7F, 5);
        chk({tag, "_fv_count"}, obs_fv, exp_fv);
        chk({tag, "_decode_err_count"}, obs_de, exp_de);
        chk({tag, "_anode_err_count"}, obs_ae, exp_ae);
        chk({tag, "_digit_seen"}, {28'd0, digit_seen}, {28'd0, m_seen});
        chk({tag, "_value"}, {16'd0, value}, {16'd0, m_value});
        chk({tag, "_err_fv_overlap"}, obs_coinc, 0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            chk({tag, "_frame_word"}, {16'd0, obs_q.pop_front()}, {16'd0, exp_q.pop_front()});
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int order [4];
        int tmp;
        int j;
        logic [15:0] word;

        AN        = 4'hF;
        sevenPlus = 8'hFF;
        rst       = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_value", {16'd0, value}, 0);
        chk("reset_frame_valid", {31'd0, frame_valid}, 0);
        chk("reset_digit_seen", {28'd0, digit_seen}, 0);
        chk("reset_decode_err", {31'd0, decode_err}, 0);
        chk("reset_anode_err", {31'd0, anode_err}, 0);
        chk("reset_stale", {31'd0, stale}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Full scan of E5F3, twice; latency measured on the completing digit.
        for (int r = 0; r < 2; r++) begin
            digit(3, 4'hE, 40);
            digit(2, 4'h5, 40);
            digit(1, 4'hF, 40);
            digit(0, 4'h3, 40);
            chk("frame_latency", last_fv_cyc - step_t0, 2 + SETTLE + 1);
        end
        check_all("scan_E5F3");

        // Reset after two digits of a new frame.
        digit(3, 4'h1, 30);
        digit(2, 4'h2, 30);
        check_all("partial_before_reset");
        rst = 1'b1;
        #1;
        chk("midreset_value", {16'd0, value}, 0);
        chk("midreset_digit_seen", {28'd0, digit_seen}, 0);
        chk("midreset_frame_valid", {31'd0, frame_valid}, 0);
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        prev_drv = 11'h7FF;
        model_reset();
        digit(3, 4'h1, 30);
        digit(2, 4'h2, 30);
        digit(1, 4'h3, 30);
        digit(0, 4'h4, 30);
        check_all("scan_1234");

        // One short of settling, then changed: nothing captured.
        digit(1, 4'h7, 20);
        do_step(4'b1110, 7'h40, SETTLE - 1);
        do_step(4'b1110, 7'h79, SETTLE - 1);
        check_all("short_hold");

        // Two anodes low.
        do_step(4'b0011, 7'h40, 40);
        check_all("anode_err");

        // Blank glyph on a valid anode.
        do_step(4'b1110, 7'h7F, 40);
        check_all("decode_err");

        // Randomized scans with glitches, junk patterns and re-captures.
        for (int f = 0; f < 8; f++) begin
            word = 16'($urandom);
            for (int i = 0; i < 4; i++) order[i] = i;
            for (int i = 3; i > 0; i--) begin
                j        = $urandom_range(0, i);
                tmp      = order[i];
                order[i] = order[j];
                order[j] = tmp;
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    do_step(4'($urandom_range(0, 14)), 7'($urandom), $urandom_range(1, SETTLE - 1));
                end
                if ($urandom_range(0, 5) == 0) begin
                    do_step(4'($urandom_range(0, 14)), 7'($urandom), $urandom_range(SETTLE, SETTLE + 8));
                end
                digit(order[i], word[order[i]*4 +: 4], $urandom_range(SETTLE, SETTLE + 12));
            end
            check_all("random_frame");
        end

        // Timeout: blank display from a fresh reset.
        do_reset();
        do_step(4'hF, 7'h7F, TIMEOUT - 1);
        chk("stale_before_timeout", {31'd0, stale}, 0);
        do_step(4'hF, 7'h7F, 1);
        chk("stale_at_timeout", {31'd0, stale}, 1);
        do_step(4'hF, 7'h7F, 20);
        chk("stale_held", {31'd0, stale}, 1);
        digit(0, 4'h9, 20);
        chk("stale_clear_latency", stale_fall_cyc - step_t0, 2 + SETTLE);
        chk("stale_cleared", {31'd0, stale}, 0);
        check_all("after_timeout");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time bound in case the stimulus ever stalls.
    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
